// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared load/store encodings and helper functions for the
//               data-memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    typedef enum logic [2:0] {
        LS_B   = 3'b000,
        LS_H   = 3'b001,
        LS_W   = 3'b010,
        LS_D   = 3'b011,
        LS_BU  = 3'b100,
        LS_HU  = 3'b101,
        LS_WU  = 3'b110,
        LS_BAD = 3'b111
    } ls_type_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] addr);
        logic mis;
        case (sz)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addr[0];
            SZ_W:    mis = |addr[1:0];
            default: mis = |addr[2:0];
        endcase
        return mis;
    endfunction

    // Extends the right-aligned lane to 64 bits; callers truncate to their width.
    function automatic logic [63:0] extend(input logic [63:0] data, input logic [1:0] sz,
                                           input logic uns);
        logic [63:0] r;
        case (sz)
            SZ_B:    r = {{56{data[7]  & ~uns}}, data[7:0]};
            SZ_H:    r = {{48{data[15] & ~uns}}, data[15:0]};
            SZ_W:    r = {{32{data[31] & ~uns}}, data[31:0]};
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_bank.sv
// ============================================================================
// Module      : dmem_bank
// Description : Single-port, byte-write-enable, write-first synchronous RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_bank #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16384,
    parameter     INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     en_i,
    input  logic [DATA_W/8-1:0]      we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [DATA_W-1:0]        din_i,
    output logic [DATA_W-1:0]        dout_o
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;

    // Write-first: the read port returns the word as it looks after this write.
    always_comb begin
        dout_d = mem_q[addr_i];
        for (int b = 0; b < NB; b++) begin
            if (we_i[b]) begin
                dout_d[b*8 +: 8] = din_i[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int b = 0; b < NB; b++) begin
                if (we_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= din_i[b*8 +: 8];
                end
            end
            dout_q <= dout_d;
        end
    end

    assign dout_o = dout_q;

endmodule

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// ============================================================================
// Module      : dmem_ctrl
// Description : Load/store data-memory controller in front of a single-port
//               BRAM; decodes, faults and lane-extends RV32/RV64 accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16384,
    parameter int ADDR_W    = 32,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [2:0]        req_type_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $error("dmem_ctrl: DATA_W must be 32 or 64");
    end

    logic              w_fire;
    logic [1:0]        w_sz;
    logic              w_uns;
    logic [OFF_W-1:0]  w_off;
    logic [ADDR_W-1:0] w_idx;
    logic              w_illegal;
    logic              w_misal;
    logic              w_oor;
    logic              w_err;
    logic              w_bank_en;
    logic [NB-1:0]     w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_bank_dout;
    logic [DATA_W-1:0] w_lane;

    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q,   rsp_err_d;
    logic             rd_ok_q,     rd_ok_d;
    logic [OFF_W-1:0] off_q,       off_d;
    logic [1:0]       sz_q,        sz_d;
    logic             uns_q,       uns_d;

    assign req_ready_o = ~rsp_valid_q | rsp_ready_i;
    assign w_fire      = req_valid_i & req_ready_o;

    assign w_sz  = req_type_i[1:0];
    assign w_uns = req_type_i[2];
    assign w_off = req_addr_i[OFF_W-1:0];
    assign w_idx = req_addr_i >> OFF_W;

    assign w_illegal = (req_type_i == LS_BAD)
                     | ((DATA_W == 32) & ((w_sz == SZ_D) | (req_type_i == LS_WU)))
                     | (req_we_i & w_uns);
    assign w_misal   = is_misaligned(w_sz, req_addr_i[2:0]);
    assign w_oor     = (w_idx >= ADDR_W'(DEPTH));
    assign w_err     = w_illegal | w_misal | w_oor;

    // A faulting access or one fired under reset must leave the bank untouched.
    assign w_bank_en = w_fire & ~w_err & ~rst;
    assign w_be      = req_we_i ? (NB'(size_mask(w_sz)) << w_off) : '0;

    always_comb begin
        w_wdata = req_wdata_i;
        case (w_sz)
            SZ_B:    w_wdata = {NB{req_wdata_i[7:0]}};
            SZ_H:    w_wdata = {(NB/2){req_wdata_i[15:0]}};
            SZ_W:    w_wdata = {(NB/4){req_wdata_i[31:0]}};
            default: ;
        endcase
    end

    dmem_bank #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_bank (
        .clk    (clk),
        .en_i   (w_bank_en),
        .we_i   (w_be),
        .addr_i (w_idx[IDX_W-1:0]),
        .din_i  (w_wdata),
        .dout_o (w_bank_dout)
    );

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rd_ok_d     = rd_ok_q;
        off_d       = off_q;
        sz_d        = sz_q;
        uns_d       = uns_q;
        if (w_fire) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = w_err;
            rd_ok_d     = ~req_we_i & ~w_err;
            off_d       = w_off;
            sz_d        = w_sz;
            uns_d       = w_uns;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_ok_q     <= 1'b0;
            off_q       <= '0;
            sz_q        <= '0;
            uns_q       <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rd_ok_q     <= rd_ok_d;
            off_q       <= off_d;
            sz_q        <= sz_d;
            uns_q       <= uns_d;
        end
    end

    // The bank output only moves on a fire, so the selected lane holds during a stall.
    assign w_lane      = w_bank_dout >> {off_q, 3'b000};
    assign rsp_rdata_o = rd_ok_q ? DATA_W'(extend(64'(w_lane), sz_q, uns_q)) : '0;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Directed plus randomized bench for dmem_ctrl at 32 and 64 bit
//               widths against a byte-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_ctrl;

    localparam logic [2:0] T_B = 3'b000, T_H = 3'b001, T_W = 3'b010, T_D = 3'b011;
    localparam logic [2:0] T_BU = 3'b100, T_HU = 3'b101, T_WU = 3'b110, T_BAD = 3'b111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        req_valid [2];
    logic        req_we    [2];
    logic        rsp_ready [2];
    logic [31:0] req_addr  [2];
    logic [2:0]  req_type  [2];
    logic [63:0] req_wdata [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic        rsp_err   [2];
    logic [31:0] rdata32;
    logic [63:0] rdata64;

    dmem_ctrl #(.DATA_W(32), .DEPTH(64), .ADDR_W(32), .INIT_FILE("")) u_dut32 (
        .clk(clk), .rst(rst[0]),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
        .req_addr_i(req_addr[0]), .req_type_i(req_type[0]), .req_wdata_i(req_wdata[0][31:0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_rdata_o(rdata32), .rsp_err_o(rsp_err[0])
    );

    dmem_ctrl #(.DATA_W(64), .DEPTH(32), .ADDR_W(32), .INIT_FILE("")) u_dut64 (
        .clk(clk), .rst(rst[1]),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
        .req_addr_i(req_addr[1]), .req_type_i(req_type[1]), .req_wdata_i(req_wdata[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_rdata_o(rdata64), .rsp_err_o(rsp_err[1])
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: byte-addressed memory and the expected response register.
    logic [7:0]  mm    [2][256];
    bit          mv    [2];
    bit          merr  [2];
    logic [63:0] mdata [2];

    function automatic int dw(input int d);
        return (d == 0) ? 32 : 64;
    endfunction

    function automatic int depth(input int d);
        return (d == 0) ? 64 : 32;
    endfunction

    function automatic logic [63:0] rd(input int d);
        return (d == 0) ? {32'h0, rdata32} : rdata64;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_access(input int d, input bit we, input logic [31:0] addr,
                                input logic [2:0] typ, input logic [63:0] wd);
        int          nb;
        bit          uns;
        bit          bad;
        logic [63:0] v;
        nb  = 1 << typ[1:0];
        uns = typ[2];
        bad = (typ == T_BAD) || (dw(d) == 32 && (typ == T_D || typ == T_WU)) || (we && uns);
        if ((addr % nb) != 0) bad = 1'b1;
        if ((addr / (dw(d) / 8)) >= depth(d)) bad = 1'b1;
        mv[d]    = 1'b1;
        merr[d]  = bad;
        mdata[d] = 64'h0;
        if (!bad) begin
            if (we) begin
                for (int i = 0; i < nb; i++) mm[d][addr + i] = wd[8*i +: 8];
            end else begin
                v = 64'h0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = mm[d][addr + i];
                if (!uns && nb < 8 && v[8*nb-1]) begin
                    for (int i = 8 * nb; i < 64; i++) v[i] = 1'b1;
                end
                if (dw(d) == 32) v[63:32] = 32'h0;
                mdata[d] = v;
            end
        end
    endtask

    // One clock: check the response the model expects, drive the new inputs,
    // check req_ready, then advance the model across the coming edge.
    task automatic cyc(input int d, input bit r, input bit v, input bit we,
                       input logic [31:0] a, input logic [2:0] t, input logic [63:0] wd,
                       input bit rdy);
        bit exp_rdy;
        @(negedge clk);
        chk("rsp_valid", {63'h0, rsp_valid[d]}, {63'h0, mv[d]});
        if (mv[d]) begin
            chk("rsp_err", {63'h0, rsp_err[d]}, {63'h0, merr[d]});
            chk("rsp_rdata", rd(d), mdata[d]);
        end
        rst[d]       = r;
        req_valid[d] = v;
        req_we[d]    = we;
        req_addr[d]  = a;
        req_type[d]  = t;
        req_wdata[d] = wd;
        rsp_ready[d] = rdy;
        #1;
        exp_rdy = !mv[d] || rdy;
        chk("req_ready", {63'h0, req_ready[d]}, {63'h0, exp_rdy});
        if (r) begin
            mv[d]    = 1'b0;
            merr[d]  = 1'b0;
            mdata[d] = 64'h0;
        end else if (v && exp_rdy) begin
            model_access(d, we, a, t, wd);
        end else if (rdy) begin
            mv[d] = 1'b0;
        end
    endtask

    // Spot check against a hand-derived constant one cycle after the fire.
    task automatic peek(input int d, input string tag, input bit e_err, input logic [63:0] e_data);
        @(posedge clk);
        #1;
        chk(tag, {63'h0, rsp_err[d]}, {63'h0, e_err});
        chk(tag, rd(d), e_data);
    endtask

    task automatic rand_run(input int d, input int n);
        logic [31:0] a;
        logic [2:0]  t;
        for (int i = 0; i < n; i++) begin
            t = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << t[1:0]) - 32'd1);
            cyc(d, 1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a, t,
                {$urandom, $urandom}, $urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; rsp_ready[d] = 1'b1;
            req_addr[d] = '0; req_type[d] = '0; req_wdata[d] = '0;
            mv[d] = 1'b0; merr[d] = 1'b0; mdata[d] = '0;
            for (int i = 0; i < 256; i++) mm[d][i] = 8'h00;
        end
        cyc(0, 1, 0, 0, 0, T_W, 0, 1);
        cyc(1, 1, 0, 0, 0, T_W, 0, 1);
        cyc(0, 0, 0, 0, 0, T_W, 0, 1);
        cyc(1, 0, 0, 0, 0, T_W, 0, 1);
        chk("reset_rsp_err32",   {63'h0, rsp_err[0]}, 64'h0);
        chk("reset_rsp_rdata32", rd(0), 64'h0);
        chk("reset_rsp_err64",   {63'h0, rsp_err[1]}, 64'h0);
        chk("reset_rsp_rdata64", rd(1), 64'h0);

        // Known memory contents for both banks.
        for (int a = 0; a < 256; a += 4) cyc(0, 0, 1, 1, a, T_W, 0, 1);
        for (int a = 0; a < 256; a += 8) cyc(1, 0, 1, 1, a, T_D, 0, 1);

        // ---- 32-bit controller ----
        cyc(0, 0, 1, 1, 32'h10, T_W, 64'h8000_00FF, 1);
        cyc(0, 0, 1, 0, 32'h10, T_W, 0, 1);
        peek(0, "lw_0x10", 0, 64'h8000_00FF);
        cyc(0, 0, 1, 1, 32'h21, T_B, 64'hAB, 1);
        cyc(0, 0, 1, 0, 32'h21, T_B, 0, 1);
        peek(0, "lb_0x21", 0, 64'hFFFF_FFAB);
        cyc(0, 0, 1, 0, 32'h21, T_BU, 0, 1);
        peek(0, "lbu_0x21", 0, 64'h0000_00AB);
        cyc(0, 0, 1, 0, 32'h20, T_HU, 0, 1);
        peek(0, "lhu_0x20", 0, 64'h0000_AB00);
        cyc(0, 0, 1, 0, 32'h20, T_W, 0, 1);
        peek(0, "lw_0x20", 0, 64'h0000_AB00);
        cyc(0, 0, 1, 0, 32'h13, T_H, 0, 1);
        peek(0, "lh_misaligned", 1, 64'h0);
        cyc(0, 0, 1, 1, 32'h12, T_W, 64'h1234_5678, 1);
        peek(0, "sw_misaligned", 1, 64'h0);
        cyc(0, 0, 1, 0, 32'h10, T_W, 0, 1);
        peek(0, "lw_after_bad_sw", 0, 64'h8000_00FF);
        cyc(0, 0, 1, 0, 32'h10, T_BAD, 0, 1);
        peek(0, "type_111", 1, 64'h0);
        cyc(0, 0, 1, 0, 32'h10, T_D, 0, 1);
        peek(0, "ld_on_32", 1, 64'h0);
        cyc(0, 0, 1, 0, 32'h100, T_W, 0, 1);
        peek(0, "lw_out_of_range", 1, 64'h0);
        cyc(0, 0, 1, 1, 32'h10, T_BU, 64'h55, 1);
        peek(0, "sbu_illegal", 1, 64'h0);

        // Backpressure: a store held off for three cycles must never reach memory.
        cyc(0, 0, 1, 0, 32'h10, T_W, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 32'h10, T_W, 64'hCAFE_F00D, 0);
        cyc(0, 0, 1, 0, 32'h10, T_W, 0, 1);
        peek(0, "lw_after_stall", 0, 64'h8000_00FF);

        // Streaming: eight stores then eight back-to-back loads.
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1, 32'h40 + 4 * i, T_W, 64'h1111_1111 * (i + 1), 1);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 32'h40 + 4 * i, T_W, 0, 1);
        cyc(0, 0, 0, 0, 0, T_W, 0, 1);

        rand_run(0, 400);
        cyc(0, 0, 0, 0, 0, T_W, 0, 1);
        cyc(0, 0, 0, 0, 0, T_W, 0, 1);

        // ---- 64-bit controller ----
        cyc(1, 0, 1, 1, 32'h8, T_D, 64'hDEAD_BEEF_0123_4567, 1);
        cyc(1, 0, 1, 0, 32'hC, T_WU, 0, 1);
        peek(1, "lwu_0xC", 0, 64'h0000_0000_DEAD_BEEF);
        cyc(1, 0, 1, 0, 32'hC, T_W, 0, 1);
        peek(1, "lw_0xC", 0, 64'hFFFF_FFFF_DEAD_BEEF);
        cyc(1, 0, 1, 0, 32'h8, T_D, 0, 1);
        peek(1, "ld_0x8", 0, 64'hDEAD_BEEF_0123_4567);
        cyc(1, 0, 1, 0, 32'hC, T_D, 0, 1);
        peek(1, "ld_misaligned", 1, 64'h0);
        cyc(1, 0, 1, 0, 32'hC, T_W, 0, 0);
        cyc(1, 1, 1, 1, 32'h8, T_D, 64'h0, 1);
        cyc(1, 0, 0, 0, 0, T_D, 0, 1);
        chk("rst_drops_rsp", {63'h0, rsp_valid[1]}, 64'h0);
        cyc(1, 0, 1, 0, 32'h8, T_D, 0, 1);
        peek(1, "ld_after_rst_store", 0, 64'hDEAD_BEEF_0123_4567);

        rand_run(1, 400);
        cyc(1, 0, 0, 0, 0, T_D, 0, 1);
        cyc(1, 0, 0, 0, 0, T_D, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
